// File: rtl/ps2_rx_decoder_if.sv
// PS/2 receive bundle: raw PS/2 lines in, decoded key event and frame error out.
interface ps2_rx_decoder_if;
    logic        ps2_clk_i;
    logic        ps2_data_i;
    logic [10:0] ps2_key;
    logic        frame_err;

    modport master (output ps2_clk_i, output ps2_data_i, input ps2_key, input frame_err);
    modport slave  (input ps2_clk_i, input ps2_data_i, output ps2_key, output frame_err);
endinterface

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: synchronise, filter the PS/2 clock, deframe bytes and decode scan-code prefixes.
// Optional macro PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
module ps2_rx_decoder #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               reset_n,
    ps2_rx_decoder_if.slave    bus
);
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    state_e          state_q, state_d;
    logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic            flt_clk_q, flt_clk_d;
    logic [FCW-1:0]  flt_cnt_q, flt_cnt_d;
    logic [TCW-1:0]  tout_q, tout_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
    logic [2:0]      skip_q, skip_d;
    logic [10:0]     key_q, key_d;
    logic            ferr_q, ferr_d;
    logic            fall_c;
    logic            parity_fail_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            flt_clk_q <= 1'b1;
            flt_cnt_q <= '0;
            tout_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            skip_q    <= '0;
            key_q     <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_s1_q  <= clk_s1_d;
            clk_s2_q  <= clk_s2_d;
            dat_s1_q  <= dat_s1_d;
            dat_s2_q  <= dat_s2_d;
            flt_clk_q <= flt_clk_d;
            flt_cnt_q <= flt_cnt_d;
            tout_q    <= tout_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            skip_q    <= skip_d;
            key_q     <= key_d;
            ferr_q    <= ferr_d;
        end
    end

    // Two-stage synchronisers, then a run-length filter on the PS/2 clock.
    always_comb begin
        clk_s1_d  = bus.ps2_clk_i;
        clk_s2_d  = clk_s1_q;
        dat_s1_d  = bus.ps2_data_i;
        dat_s2_d  = dat_s1_q;
        flt_clk_d = flt_clk_q;
        flt_cnt_d = '0;
        if (clk_s2_q != flt_clk_q) begin
            if (flt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                flt_clk_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FCW'(1);
            end
        end
        fall_c = flt_clk_q & ~flt_clk_d;
    end

`ifdef PS2_PARITY_CHECK_EN
    assign parity_fail_c = ~(^{shift_q, parity_q});
`else
    // Parity is captured for completeness but never rejects a frame.
    assign parity_fail_c = parity_q & 1'b0;
`endif

    // Frame FSM, prefix decoding and inter-edge timeout.
    always_comb begin
        state_d   = state_q;
        tout_d    = '0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        skip_d    = skip_q;
        key_d     = key_q;
        ferr_d    = 1'b0;

        if (state_q != IDLE && !fall_c) begin
            tout_d = tout_q + TCW'(1);
        end

        case (state_q)
            IDLE: begin
                if (fall_c) begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall_c) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_c) begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall_c) begin
                    state_d = IDLE;
                    if (!dat_s2_q || parity_fail_c) begin
                        ferr_d = 1'b1;
                    end else if (skip_q != 3'd0) begin
                        skip_d = skip_q - 3'd1;
                    end else if (shift_q == 8'hE1) begin
                        skip_d = 3'd7;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (ext_q && (shift_q == 8'h12 || shift_q == 8'h59)) begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end else begin
                        key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !fall_c && tout_q == TCW'(TIMEOUT_CYC - 1)) begin
            state_d   = IDLE;
            tout_d    = '0;
            bit_cnt_d = '0;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
            skip_d    = '0;
            ferr_d    = 1'b1;
        end
    end

    assign bus.ps2_key   = key_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: doc/ps2_rx_decoder.md
PS2_RX_DECODER -- requirements
Module: ps2_rx_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical samples required before the filtered PS/2 clock level changes.
REQ-002 Parameter TIMEOUT_CYC, default 100000: clk cycles allowed between PS/2 clock falling edges inside a frame (2 ms at 50 MHz).
REQ-003 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  core clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 ps2_clk_i  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 ps2_data_i  input  1  raw PS/2 data line, asynchronous to clk.
REQ-008 ps2_key  output  11  key event to the keyboard matrix stage: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code.
REQ-009 frame_err  output  1  one-cycle pulse per rejected frame.

Function
REQ-010 ps2_clk_i and ps2_data_i SHALL each pass through a 2-FF synchronizer before any other use.
REQ-011 Filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples differ from the current filtered level; a falling edge is a 1->0 change of the filtered clock.
REQ-012 Synchronized data SHALL be sampled only in the cycle in which the filtered clock falling edge is detected.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on a falling edge with data=0, go to DATA with bit count 0; with data=1, stay in IDLE and pulse frame_err.
REQ-015 DATA: shift 8 bits LSB first, one per falling edge; go to PARITY after the 8th bit.
REQ-016 PARITY: latch the parity bit on the next falling edge and go to STOP.
REQ-017 STOP: on the next falling edge, return to IDLE.
REQ-018 STOP, stop bit=0: discard the byte and pulse frame_err.
REQ-019 Timeout: outside IDLE, TIMEOUT_CYC cycles with no falling edge SHALL force IDLE, discard the partial byte, clear the prefix flags and the skip counter, and pulse frame_err.
REQ-020 Accepted byte 0xE0: set the extended flag; no output.
REQ-021 Accepted byte 0xF0: set the break flag; no output.
REQ-022 Accepted byte 0xE1: load the skip counter with 7; the next 7 accepted bytes SHALL be dropped with no output and no flag changes (Pause sequence).
REQ-023 Accepted byte 0x12 or 0x59 with the extended flag set (fake shift) SHALL be dropped, with both flags cleared.
REQ-024 Any other accepted byte SHALL drive ps2_key <= {~ps2_key[10], ~break, extended, byte}, then clear both flags.
REQ-025 Latency: ps2_key and frame_err SHALL update exactly 1 clk after the cycle in which the stop-bit falling edge is detected.
REQ-026 ps2_key SHALL hold its value between events; bit 10 toggles exactly once per emitted event.
REQ-027 A byte arriving while the skip counter is nonzero SHALL decrement the counter even when it is 0xE0 or 0xF0.
REQ-028 A frame error SHALL leave the prefix flags and skip counter unchanged, except on timeout (REQ-019).

Reset
REQ-029 reset_n=0 SHALL, on the next clk edge, set state=IDLE, ps2_key=11'h000, frame_err=0, both flags=0, skip counter=0, timeout counter=0, bit count=0.
REQ-030 Filtered clock and synchronizers SHALL reset to 1 (line idle).
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no output and no frame_err.
REQ-032 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-033 Macro PS2_PARITY_CHECK_EN defined: in STOP, a byte failing odd parity (data bits plus parity bit not odd) SHALL be discarded with a frame_err pulse.
REQ-034 Macro PS2_PARITY_CHECK_EN undefined: the parity bit SHALL be latched but ignored, and no parity frame_err is ever generated.

Verification
REQ-035 Reset, then frame 0x1C with correct parity -> 1 clk after the stop edge, ps2_key=11'b1_1_0_00011100, frame_err=0.
REQ-036 Frames F0,1C after REQ-035 -> one event only, ps2_key=11'b0_0_0_00011100.
REQ-037 Frames E0,F0,75 -> one event, ps2_key[9:0]=10'b0_1_01110101, bit 10 toggled; then E0,12 -> no event, flags cleared.
REQ-038 Pause sequence E1,14,77,E1,F0,14,F0,77, then 0x29 -> exactly one event, ps2_key[9:0]=10'b1_0_00101001.
REQ-039 Frame 0x1C with wrong parity -> with PS2_PARITY_CHECK_EN, frame_err pulse and no event; without it, event as REQ-035.
REQ-040 Start bit plus 4 data bits, then clock held high for TIMEOUT_CYC cycles -> frame_err pulse, state IDLE; the following good frame 0x1C decodes correctly. 1-cycle glitches (< FILTER_LEN) on ps2_clk_i throughout -> no extra bits sampled.
